// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem port, decode handshake, redirect/halt control
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        resume;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  // fetch unit side
  modport master (
    output imem_addr,
    input  imem_inst,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    input  redirect_valid,
    input  redirect_target,
    input  resume,
    output halted,
    output misalign_err,
    output fetch_count
  );

  // memory / decode / control side
  modport slave (
    input  imem_addr,
    output imem_inst,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    output redirect_valid,
    output redirect_target,
    output resume,
    input  halted,
    input  misalign_err,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry output register
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT, ERROR} state_t;

  state_t      state, state_n;
  logic [31:0] pc;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] opc_q;
  logic        halted_q;
  logic        err_q;
  logic [31:0] count_q;

  logic        xfer;
  logic        capture;
  logic        redirect;
  logic        misalign;

  assign xfer = valid_q && bus.out_ready;

  // imem address comes straight from the pc register, never from inputs
  assign bus.imem_addr    = pc;
  assign bus.out_valid    = valid_q;
  assign bus.out_inst     = inst_q;
  assign bus.out_pc       = opc_q;
  assign bus.halted       = halted_q;
  assign bus.misalign_err = err_q;
  assign bus.fetch_count  = count_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state plus capture/redirect decisions; any redirect request blocks capture
  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    redirect = 1'b0;
    misalign = 1'b0;
    if (state != ERROR && bus.redirect_valid) begin
      if (bus.redirect_target[1:0] != 2'b00) misalign = 1'b1;
      else                                   redirect = 1'b1;
    end
    case (state)
      IDLE:  state_n = FETCH;
      FETCH: begin
        if (!bus.redirect_valid && (!valid_q || xfer)) begin
          capture = 1'b1;
          if (bus.imem_inst == EBREAK_INST) state_n = HALT;
        end
      end
      HALT:  if (bus.resume) state_n = FETCH;
      ERROR: state_n = ERROR;
      default: state_n = IDLE;
    endcase
    if (misalign) state_n = ERROR;
  end

  // pc, output register, status flags and transfer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      valid_q  <= 1'b0;
      inst_q   <= NOP_INST;
      opc_q    <= 32'h0000_0000;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 32'h0000_0000;
    end else begin
      if (xfer) count_q <= count_q + 32'd1;
      halted_q <= (state_n == HALT);
      if (misalign) begin
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
        err_q   <= 1'b1;
      end else if (redirect) begin
        pc      <= bus.redirect_target;
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
      end else if (capture) begin
        inst_q  <= bus.imem_inst;
        opc_q   <= pc;
        valid_q <= 1'b1;
        pc      <= pc + 32'd4;
      end else if (xfer) begin
        // entry drained with nothing to replace it (HALT)
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EB  = 32'h0010_0073;

  logic clk;
  logic rst;
  logic rst2;
  bit   ebreak_at8;
  int   vectors;
  int   miscompares;
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  fetch_unit_if b1();
  fetch_unit_if b2();

  fetch_unit dut1 (.clk(clk), .rst(rst), .bus(b1));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst(rst2), .bus(b2));

  assign b1.imem_inst = (ebreak_at8 && b1.imem_addr == 32'd8) ? EB : {16'hC0DE, b1.imem_addr[15:0]};
  assign b2.imem_inst = {16'hC0DE, b2.imem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) check("mon1_unexpected_pc", b1.out_pc, 32'hXXXX_XXXX);
      else begin
        e = q1.pop_front();
        check("mon1_inst", b1.out_inst, e[63:32]);
        check("mon1_pc", b1.out_pc, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (b2.out_valid && b2.out_ready) begin
      if (q2.size() == 0) check("mon2_unexpected_pc", b2.out_pc, 32'hXXXX_XXXX);
      else begin
        e = q2.pop_front();
        check("mon2_inst", b2.out_inst, e[63:32]);
        check("mon2_pc", b2.out_pc, e[31:0]);
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    ebreak_at8 = 0;
    rst = 1; rst2 = 1;
    b1.out_ready = 1; b1.redirect_valid = 0; b1.redirect_target = 0; b1.resume = 0;
    b2.out_ready = 1; b2.redirect_valid = 0; b2.redirect_target = 0; b2.resume = 0;
    tick(2);
    check("rst_valid", 32'(b1.out_valid), 0);
    check("rst_inst", b1.out_inst, NOP);
    check("rst_pc", b1.out_pc, 0);
    check("rst_addr", b1.imem_addr, 0);
    check("rst_halted", 32'(b1.halted), 0);
    check("rst_err", 32'(b1.misalign_err), 0);
    check("rst_count", b1.fetch_count, 0);

    // sequential fetch, stall, release
    rst = 0;
    q1.push_back({word(0), 32'd0});
    q1.push_back({word(4), 32'd4});
    q1.push_back({word(8), 32'd8});
    q1.push_back({word(12), 32'd12});
    q1.push_back({word(16), 32'd16});
    tick(1);
    check("idle_valid", 32'(b1.out_valid), 0);
    tick(1);
    check("first_valid", 32'(b1.out_valid), 1);
    check("first_pc", b1.out_pc, 0);
    check("first_inst", b1.out_inst, word(0));
    tick(2);
    check("b2b_pc", b1.out_pc, 8);
    check("b2b_count", b1.fetch_count, 2);
    b1.out_ready = 0;
    tick(3);
    check("stall_pc", b1.out_pc, 8);
    check("stall_valid", 32'(b1.out_valid), 1);
    check("stall_inst", b1.out_inst, word(8));
    check("stall_addr", b1.imem_addr, 12);
    check("stall_count", b1.fetch_count, 2);
    b1.out_ready = 1;
    tick(1);
    check("release_pc", b1.out_pc, 12);
    check("release_count", b1.fetch_count, 3);
    tick(1);
    check("count4", b1.fetch_count, 4);

    // redirect with a same-cycle transfer
    q1.push_back({word(32'h40), 32'h40});
    b1.redirect_valid = 1; b1.redirect_target = 32'h40;
    tick(1);
    b1.redirect_valid = 0;
    check("redir_valid", 32'(b1.out_valid), 0);
    check("redir_inst", b1.out_inst, NOP);
    check("redir_count", b1.fetch_count, 5);
    check("redir_addr", b1.imem_addr, 32'h40);
    tick(1);
    check("redir_pc", b1.out_pc, 32'h40);

    // ebreak at 8 halts after delivery, resume continues at 12
    ebreak_at8 = 1;
    q1.push_back({EB, 32'd8});
    b1.redirect_valid = 1; b1.redirect_target = 32'd8;
    tick(1);
    b1.redirect_valid = 0;
    check("eb_redir_count", b1.fetch_count, 6);
    tick(1);
    check("eb_halted", 32'(b1.halted), 1);
    check("eb_pc", b1.out_pc, 8);
    check("eb_inst", b1.out_inst, EB);
    check("eb_addr", b1.imem_addr, 12);
    tick(1);
    check("halt_drain_valid", 32'(b1.out_valid), 0);
    check("halt_drain_count", b1.fetch_count, 7);
    tick(2);
    check("halt_idle_valid", 32'(b1.out_valid), 0);
    check("halt_still", 32'(b1.halted), 1);
    q1.push_back({word(12), 32'd12});
    b1.resume = 1;
    tick(1);
    b1.resume = 0;
    check("resume_halted", 32'(b1.halted), 0);
    tick(1);
    check("resume_pc", b1.out_pc, 12);
    check("resume_valid", 32'(b1.out_valid), 1);

    // misaligned redirect is terminal
    b1.redirect_valid = 1; b1.redirect_target = 32'h42;
    tick(1);
    check("mis_err", 32'(b1.misalign_err), 1);
    check("mis_valid", 32'(b1.out_valid), 0);
    check("mis_count", b1.fetch_count, 8);
    check("mis_addr", b1.imem_addr, 16);
    b1.redirect_target = 32'h80; b1.resume = 1;
    tick(3);
    b1.redirect_valid = 0; b1.resume = 0;
    tick(1);
    check("err_valid", 32'(b1.out_valid), 0);
    check("err_addr", b1.imem_addr, 16);
    check("err_sticky", 32'(b1.misalign_err), 1);

    // asynchronous reset mid-cycle
    #2 rst = 1;
    #1;
    check("arst_err", 32'(b1.misalign_err), 0);
    check("arst_valid", 32'(b1.out_valid), 0);
    check("arst_count", b1.fetch_count, 0);
    check("arst_addr", b1.imem_addr, 0);
    check("arst_inst", b1.out_inst, NOP);

    // pc wraps from FFFF_FFFC to 0 without error
    tick(1);
    ebreak_at8 = 0;
    q2.push_back({word(32'hFFFF_FFF8), 32'hFFFF_FFF8});
    q2.push_back({word(32'hFFFF_FFFC), 32'hFFFF_FFFC});
    q2.push_back({word(32'h0), 32'h0});
    rst2 = 0;
    tick(2);
    check("wrap_pc0", b2.out_pc, 32'hFFFF_FFF8);
    tick(1);
    check("wrap_pc1", b2.out_pc, 32'hFFFF_FFFC);
    tick(1);
    check("wrap_pc2", b2.out_pc, 32'h0);
    tick(1);
    b2.out_ready = 0;
    check("wrap_count", b2.fetch_count, 3);
    check("wrap_err", 32'(b2.misalign_err), 0);
    tick(2);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter and drives the byte address into instruction memory.
- Captures the returned word into a one-entry output register.
- Hands {instruction, pc} to decode over a valid/ready handshake; handles redirects (branch/jump), ebreak halt/resume, misaligned-target error and a retired-fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_INST, 32'h0000_0013, value of out_inst whenever out_valid=0 (addi x0,x0,0).
EBREAK_INST, 32'h0010_0073, encoding that triggers HALT after delivery.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  32  byte address to instruction memory; combinational, equals pc
imem_inst  input  32  instruction word returned combinationally for imem_addr
out_valid  output  1  out_inst/out_pc hold a valid fetched instruction
out_ready  input  1  decode accepts the entry this cycle
out_inst  output  32  fetched instruction
out_pc  output  32  address the instruction was fetched from
redirect_valid  input  1  load a new PC this cycle (branch/jump taken)
redirect_target  input  32  new PC byte address
resume  input  1  single-cycle pulse; leave HALT
halted  output  1  high while in HALT
misalign_err  output  1  sticky; redirect target had target[1:0]!=0
fetch_count  output  32  number of completed out handshakes, wraps mod 2^32

Behaviour:
- Reset (async assert, any state): pc=RESET_PC, state=IDLE, out_valid=0, out_inst=NOP_INST, out_pc=0, halted=0, misalign_err=0, fetch_count=0.
- States:
  - IDLE: one cycle after reset release, no fetch; then -> FETCH.
  - FETCH: normal operation.
  - HALT: no fetching.
  - ERROR: terminal until reset.
- Handshake:
  - Transfer occurs when out_valid && out_ready; fetch_count increments by 1 on each transfer.
  - out_valid, out_inst and out_pc are stable while out_valid=1 and out_ready=0.
- Capture (FETCH only, no redirect): when out_valid=0 or a transfer occurs, register out_inst<=imem_inst, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - Back-to-back: one instruction per cycle with out_ready held high.
  - Latency: first out_valid=1 appears 2 cycles after reset release (IDLE, then capture).
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.
- Redirect (highest priority after reset, any state except ERROR):
  - pc<=redirect_target, out_valid<=0, out_inst<=NOP_INST; no capture that cycle.
  - A transfer in the same cycle still counts.
  - Fetch from the new pc starts the following cycle if in FETCH.
- Misaligned redirect (redirect_target[1:0]!=0): pc unchanged, out_valid<=0, misalign_err<=1, state -> ERROR.
  - In ERROR: no fetches, out_valid stays 0, all other inputs ignored.
- Ebreak: when a capture loads imem_inst==EBREAK_INST, state -> HALT on the same edge and halted<=1.
  - The ebreak entry remains valid and is delivered normally under the handshake.
  - pc has advanced past it.
- HALT:
  - No new captures; out_valid drops after the pending entry transfers.
  - resume -> FETCH next cycle, halted<=0.
  - Redirect in HALT updates pc, flushes the output and stays HALT unless resume is also high (then -> FETCH).
  - resume outside HALT is ignored.
- imem_addr is purely combinational from the pc register; no combinational path from out_ready or redirect to imem_addr.

Test Plan:
- Reset, out_ready=1, memory words 0..3 = A,B,C,D -> out_valid first high cycle 2 with out_pc=0, out_inst=A; then pc 4,8,12 on consecutive cycles; fetch_count=4 after 4 transfers.
- out_ready=0 for 3 cycles while out_valid=1 (out_pc=8) -> outputs frozen, imem_addr stays 12, fetch_count unchanged; release -> out_pc=12 next cycle.
- redirect_valid with target=32'h40 while out_pc=4 valid and out_ready=1 -> fetch_count increments, next cycle out_valid=0, following cycle out_pc=32'h40.
- Word at 8 = 32'h0010_0073 -> delivered with out_pc=8, halted=1, no further valid; resume pulse -> next entry out_pc=12.
- redirect_target=32'h42 -> misalign_err=1, out_valid=0 permanently; later redirects and resume ignored; async rst clears all to reset values.
- RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, no error.
